// File: rtl/ppu_quant.sv
// ppu_quant: requantizes a tile of ROWS rows, 16 signed 24-bit lanes per row,
// into 16 byte lanes (int8 or int4) through a two-stage valid/ready pipeline.
//   clk, rst_n                     clock, asynchronous active-low reset
//   start                          begins a tile in IDLE, samples the config inputs
//   shift_amt, relu_en,
//   is_int4_mode                   per-tile requantization config
//   in_valid, in_ready, in_row     input row handshake (lane i at [24i+23:24i])
//   out_valid, out_ready, out_row  output row handshake (lane i at [8i+7:8i])
//   row_idx                        index of the row presented on out_row
//   busy                           tile in progress (RUN or DRAIN)
//   done                           one-cycle pulse after the final output transfer
module ppu_quant #(
    parameter int unsigned ROWS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   shift_amt,
    input  logic         relu_en,
    input  logic         is_int4_mode,
    input  logic         in_valid,
    input  logic [383:0] in_row,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_row,
    output logic [3:0]   row_idx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned LANES     = 16;
    localparam int unsigned IN_W      = 24;
    localparam int unsigned EXT_W     = 25;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned SH_W      = 5;
    localparam logic [SH_W-1:0] MAX_SHIFT = SH_W'(23);

    localparam logic signed [EXT_W-1:0] ZERO   = '0;
    localparam logic signed [EXT_W-1:0] I8_MAX = 25'sd127;
    localparam logic signed [EXT_W-1:0] I8_MIN = -25'sd128;
    localparam logic signed [EXT_W-1:0] I4_MAX = 25'sd7;
    localparam logic signed [EXT_W-1:0] I4_MIN = -25'sd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
    logic [SH_W-1:0]          shift_q, shift_d;
    logic                     relu_q, relu_d;
    logic                     int4_q, int4_d;

    logic                     s1_valid_q;
    logic [LANES*EXT_W-1:0]   s1_data_q;
    logic [IDX_W-1:0]         s1_idx_q;
    logic                     s2_valid_q;
    logic [LANES*OUT_W-1:0]   out_row_q;
    logic [IDX_W-1:0]         row_idx_q;
    logic                     done_q;

    logic                     s1_adv, s2_adv, in_xfer, out_xfer, last_out;
    logic [SH_W-1:0]          eff_shift;
    logic [LANES*EXT_W-1:0]   rnd_row;
    logic [LANES*OUT_W-1:0]   sat_row;

    // A stage may load when it is empty or its content moves on this cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = (state_q == RUN) && (in_cnt_q < CNT_W'(ROWS)) && s1_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;
    assign last_out = (state_q == DRAIN) && out_xfer && (out_cnt_q == CNT_W'(ROWS - 1));

    assign out_valid = s2_valid_q;
    assign out_row   = out_row_q;
    assign row_idx   = row_idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Next-state, counters and config capture.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        int4_d    = int4_q;
        if (in_xfer) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (out_xfer) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    shift_d   = shift_amt;
                    relu_d    = relu_en;
                    int4_d    = is_int4_mode;
                end
            end
            RUN: begin
                if (in_xfer && (in_cnt_q == CNT_W'(ROWS - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            int4_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            int4_q    <= int4_d;
        end
    end

    assign eff_shift = (shift_q > MAX_SHIFT) ? MAX_SHIFT : shift_q;

    // Stage-1 datapath: round half up then arithmetic shift; 25 bits cannot overflow.
    always_comb begin : round_lanes
        logic signed [EXT_W-1:0] x;
        logic signed [EXT_W-1:0] bias;
        logic signed [EXT_W-1:0] sum;
        x       = '0;
        bias    = '0;
        sum     = '0;
        rnd_row = '0;
        for (int i = 0; i < LANES; i++) begin
            x    = {in_row[i*IN_W + IN_W - 1], in_row[i*IN_W +: IN_W]};
            bias = (eff_shift == '0) ? ZERO : (EXT_W'(1) << (eff_shift - SH_W'(1)));
            sum  = x + bias;
            rnd_row[i*EXT_W +: EXT_W] = sum >>> eff_shift;
        end
    end

    // Stage-2 datapath: optional ReLU, then saturate to int8 or int4.
    always_comb begin : sat_lanes
        logic signed [EXT_W-1:0] v;
        v       = '0;
        sat_row = '0;
        for (int i = 0; i < LANES; i++) begin
            v = s1_data_q[i*EXT_W +: EXT_W];
            if (relu_q && (v < ZERO)) begin
                v = ZERO;
            end
            if (int4_q) begin
                if (v > I4_MAX) begin
                    v = I4_MAX;
                end else if (v < I4_MIN) begin
                    v = I4_MIN;
                end
                sat_row[i*OUT_W +: OUT_W] = {4'b0000, v[3:0]};
            end else begin
                if (v > I8_MAX) begin
                    v = I8_MAX;
                end else if (v < I8_MIN) begin
                    v = I8_MIN;
                end
                sat_row[i*OUT_W +: OUT_W] = v[7:0];
            end
        end
    end

    // Pipeline registers; both stages hold while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            out_row_q  <= '0;
            row_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_xfer;
                if (in_xfer) begin
                    s1_data_q <= rnd_row;
                    s1_idx_q  <= IDX_W'(in_cnt_q);
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_row_q <= sat_row;
                    row_idx_q <= s1_idx_q;
                end
            end
            done_q <= last_out;
        end
    end

endmodule

// File: tb/tb_ppu_quant.sv
// Bench for ppu_quant: randomized rows and configs, scoreboard queue filled by the
// driver from an arithmetic reference model, drained by an independent monitor.
module tb_ppu_quant;

    localparam int ROWS = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   shift_amt;
    logic         relu_en;
    logic         is_int4_mode;
    logic         in_valid;
    logic [383:0] in_row;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_row;
    logic [3:0]   row_idx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    ppu_quant #(.ROWS(ROWS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .shift_amt    (shift_amt),
        .relu_en      (relu_en),
        .is_int4_mode (is_int4_mode),
        .in_valid     (in_valid),
        .in_row       (in_row),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .row_idx      (row_idx),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [127:0] row;
        logic [3:0]   idx;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   tiles    = 0;
    int   tile_row = 0;
    int   m_shift  = 0;
    bit   m_relu   = 0;
    bit   m_int4   = 0;
    bit   lat_check = 0;
    bit   rnd_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: round half up of x / 2^s, then ReLU, then clamp.
    function automatic logic [7:0] model_lane(int x, int sh, bit relu, bit i4);
        int s;
        int y;
        s = (sh > 23) ? 23 : sh;
        if (s == 0) y = x;
        else        y = (x + (1 << (s - 1))) >>> s;
        if (relu && y < 0) y = 0;
        if (i4) begin
            if (y > 7)  y = 7;
            if (y < -8) y = -8;
            return {4'b0000, 4'(y)};
        end
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return 8'(y);
    endfunction

    function automatic logic [127:0] model_row(logic [383:0] r);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[i*8 +: 8] = model_lane(int'($signed(r[i*24 +: 24])), m_shift, m_relu, m_int4);
        end
        return o;
    endfunction

    function automatic logic [383:0] rand_row();
        logic [383:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       v = int'($urandom);
                1:       v = int'($urandom_range(0, 600)) - 300;
                default: v = int'($urandom_range(0, 131072)) - 65536;
            endcase
            r[i*24 +: 24] = 24'(v);
        end
        return r;
    endfunction

    // Random output back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks protocol rules.
    int           inflight   = 0;
    bit           exp_done   = 0;
    bit           prev_stall = 0;
    logic [127:0] prev_row;
    logic [3:0]   prev_idx;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_out_valid", 128'(out_valid), 128'(0));
            check("rst_in_ready", 128'(in_ready), 128'(0));
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_done", 128'(done), 128'(0));
            check("rst_out_row", out_row, 128'(0));
            check("rst_row_idx", 128'(row_idx), 128'(0));
            inflight   = 0;
            exp_done   = 0;
            prev_stall = 0;
        end else begin
            check("done_pulse", 128'(done), 128'(exp_done));
            if (exp_done) check("busy_at_done", 128'(busy), 128'(0));
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_row", out_row, prev_row);
                check("stall_idx", 128'(row_idx), 128'(prev_idx));
            end
            if (inflight == 2 && !out_ready) check("in_ready_full", 128'(in_ready), 128'(0));
            exp_done = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got row %h idx %0d expected none", out_row, row_idx);
                end else begin
                    e = sb.pop_front();
                    check("out_row", out_row, e.row);
                    check("row_idx", 128'(row_idx), 128'(e.idx));
                    if (lat_check) check("latency", 128'(cyc), 128'(e.cyc + 2));
                    if (int'(e.idx) == ROWS - 1) exp_done = 1;
                end
            end
            inflight += int'(in_valid && in_ready) - int'(out_valid && out_ready);
            prev_stall = out_valid && !out_ready;
            prev_row   = out_row;
            prev_idx   = row_idx;
        end
    end

    task automatic start_tile(int sh, bit relu, bit i4, bit apply);
        start        = 1'b1;
        shift_amt    = 5'(sh);
        relu_en      = relu;
        is_int4_mode = i4;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (apply) begin
            m_shift  = sh;
            m_relu   = relu;
            m_int4   = i4;
            tile_row = 0;
        end
    endtask

    task automatic send_row(logic [383:0] r, logic [127:0] ex);
        exp_t e;
        in_valid = 1'b1;
        in_row   = r;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.row = ex;
                e.idx = 4'(tile_row);
                e.cyc = cyc;
                sb.push_back(e);
                tile_row++;
                @(posedge clk);
                #1;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
    endtask

    task automatic send_rand(int n);
        logic [383:0] r;
        for (int k = 0; k < n; k++) begin
            r = rand_row();
            send_row(r, model_row(r));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_tile();
        tiles++;
        for (int t = 0; t < 500 && done_cnt < tiles; t++) @(negedge clk);
        check("done_count", 128'(done_cnt), 128'(tiles));
        @(posedge clk);
        #1;
    endtask

    logic [383:0] drow;
    logic [127:0] dexp;

    initial begin
        rst_n = 1'b0; start = 1'b0; shift_amt = '0; relu_en = 1'b0; is_int4_mode = 1'b0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All lanes 24 >> 4 with rounding -> 2, back-to-back, fixed latency.
        lat_check = 1;
        start_tile(4, 0, 0, 1);
        drow = {16{24'h000018}};
        dexp = {16{8'h02}};
        for (int k = 0; k < ROWS; k++) send_row(drow, dexp);
        in_valid = 1'b0;
        wait_tile();
        lat_check = 0;

        // int8 saturation without and with ReLU.
        drow = '0;
        drow[23:0]  = 24'd1000;
        drow[47:24] = 24'hFFFC18;
        dexp = '0;
        dexp[7:0]  = 8'h7F;
        dexp[15:8] = 8'h80;
        start_tile(0, 0, 0, 1);
        send_row(drow, dexp);
        send_rand(ROWS - 1);
        wait_tile();
        dexp[15:8] = 8'h00;
        start_tile(0, 1, 0, 1);
        send_row(drow, dexp);
        send_rand(ROWS - 1);
        wait_tile();

        // int4 saturation and negative rounding.
        drow = '0;
        drow[23:0]  = 24'd40;
        drow[47:24] = 24'hFFFFF7;
        drow[71:48] = 24'hFFFFD8;
        dexp = '0;
        dexp[7:0]   = 8'h07;
        dexp[15:8]  = 8'h0E;
        dexp[23:16] = 8'h08;
        start_tile(2, 0, 1, 1);
        send_row(drow, dexp);
        send_rand(ROWS - 1);
        wait_tile();

        // Random back-pressure.
        rnd_ready = 1;
        start_tile(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        send_rand(ROWS);
        wait_tile();

        // Reset in the middle of a tile, then a fresh tile.
        start_tile(int'($urandom_range(0, 31)), 0, 0, 1);
        send_rand(7);
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_tile(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        send_rand(ROWS);
        wait_tile();

        // start during RUN must not change the active config.
        rnd_ready = 0;
        out_ready = 1'b1;
        start_tile(3, 0, 0, 1);
        send_rand(5);
        start_tile(0, 1, 1, 0);
        send_rand(ROWS - 5);
        wait_tile();

        // Extra random tiles, including shifts above 23.
        rnd_ready = 1;
        for (int t = 0; t < 3; t++) begin
            start_tile(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            send_rand(ROWS);
            wait_tile();
        end
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
